// File: rtl/writeback_register_file_if.sv
// Writeback bundle between the MEM/WB register, the register file and the ID-stage read ports.
// Latency: none; this is a signal bundle only.
// Backpressure: none; the writeback side commits every presented write unconditionally.
interface writeback_register_file_if #(
    parameter int N = 32
);
    logic         WB_MemRead;
    logic         WB_RegWrite;
    logic [N-1:0] WB_DataMemory_Data;
    logic [N-1:0] WB_ALUResult;
    logic [4:0]   WB_WriteRegister;
    logic [4:0]   ReadRegister1;
    logic [4:0]   ReadRegister2;
    logic [N-1:0] ReadData1;
    logic [N-1:0] ReadData2;
    logic [N-1:0] WB_WriteData;
    logic         WB_WriteValid;
    logic [N-1:0] RetiredWrites;

    // Pipeline / ID-stage side: drives controls and indices, observes read data.
    modport master (
        output WB_MemRead, WB_RegWrite, WB_DataMemory_Data, WB_ALUResult,
               WB_WriteRegister, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, WB_WriteData, WB_WriteValid, RetiredWrites
    );

    // Register file side.
    modport slave (
        input  WB_MemRead, WB_RegWrite, WB_DataMemory_Data, WB_ALUResult,
               WB_WriteRegister, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, WB_WriteData, WB_WriteValid, RetiredWrites
    );
endinterface

// File: rtl/writeback_register_file.sv
// Writeback select, 32-entry register file with two bypassed async read ports, write statistics.
// Latency: write data visible on read ports in the same cycle (bypass), from storage next cycle.
// Backpressure: none; every effective write is committed on the next rising edge.
module writeback_register_file #(
    parameter int          N        = 32,
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_RESET = 32'h1000_8000
) (
    input logic                      clk,
    input logic                      reset,
    writeback_register_file_if.slave wb
);
    logic [N-1:0] regs [32];
    logic [N-1:0] writeData;
    logic         writeEn;
    logic         writeValid;
    logic [N-1:0] retiredWrites;
    logic [N-1:0] readData1;
    logic [N-1:0] readData2;

    // Load data wins over the ALU result whenever the instruction was a load.
    assign writeData = wb.WB_MemRead ? wb.WB_DataMemory_Data : wb.WB_ALUResult;
    // r0 is hardwired, so a write aimed at it is not a real write at all.
    assign writeEn   = wb.WB_RegWrite && (wb.WB_WriteRegister != 5'd0);

    // Register storage; r0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            regs[28] <= N'(GP_RESET);
            regs[29] <= N'(SP_RESET);
        end else if (writeEn) begin
            regs[wb.WB_WriteRegister] <= writeData;
        end
    end

    // Write-valid pulse and retired-write counter; the counter wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            writeValid    <= 1'b0;
            retiredWrites <= '0;
        end else begin
            writeValid <= writeEn;
            if (writeEn) begin
                retiredWrites <= retiredWrites + N'(1);
            end
        end
    end

    // Read port 1: r0 forced to zero, then same-cycle bypass of the writeback value, then storage.
    always_comb begin
        if (wb.ReadRegister1 == 5'd0) begin
            readData1 = '0;
        end else if (writeEn && (wb.WB_WriteRegister == wb.ReadRegister1)) begin
            readData1 = writeData;
        end else begin
            readData1 = regs[wb.ReadRegister1];
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        if (wb.ReadRegister2 == 5'd0) begin
            readData2 = '0;
        end else if (writeEn && (wb.WB_WriteRegister == wb.ReadRegister2)) begin
            readData2 = writeData;
        end else begin
            readData2 = regs[wb.ReadRegister2];
        end
    end

    assign wb.WB_WriteData  = writeData;
    assign wb.ReadData1     = readData1;
    assign wb.ReadData2     = readData2;
    assign wb.WB_WriteValid = writeValid;
    assign wb.RetiredWrites = retiredWrites;
endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for the writeback register file: a 32-bit instance for function, an 8-bit one for counter wrap.
// Latency: expected values are queued when stimulus is driven and popped when the output is sampled.
// Backpressure: not applicable; the design has no stall input.
module tb_writeback_register_file;
    logic clk;
    logic reset;

    writeback_register_file_if #(.N(32)) if32 ();
    writeback_register_file_if #(.N(8))  if8 ();

    writeback_register_file #(.N(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .wb    (if32.slave)
    );

    writeback_register_file #(.N(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .wb    (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] expQ [$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        expQ.push_back(v);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
        end else begin
            expv = expQ.pop_front();
            assert (obs === expv) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
            end
        end
    endtask

    task automatic setW(input logic mr, input logic rw, input logic [31:0] dm,
                        input logic [31:0] alu, input logic [4:0] wr);
        if32.WB_MemRead         = mr;
        if32.WB_RegWrite        = rw;
        if32.WB_DataMemory_Data = dm;
        if32.WB_ALUResult       = alu;
        if32.WB_WriteRegister   = wr;
    endtask

    task automatic setRd(input logic [4:0] r1, input logic [4:0] r2);
        if32.ReadRegister1 = r1;
        if32.ReadRegister2 = r2;
    endtask

    initial begin
        reset = 1'b0;
        setW(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        setRd(5'd0, 5'd0);
        if8.WB_MemRead         = 1'b0;
        if8.WB_RegWrite        = 1'b0;
        if8.WB_DataMemory_Data = 8'h00;
        if8.WB_ALUResult       = 8'h00;
        if8.WB_WriteRegister   = 5'd0;
        if8.ReadRegister1      = 5'd0;
        if8.ReadRegister2      = 5'd0;
        #12;
        reset = 1'b1;

        // Dirty some state, then reset mid-run with a write still being presented.
        setW(1'b0, 1'b1, 32'h0, 32'h0000_0055, 5'd5);
        tick();
        setRd(5'd5, 5'd0);
        #1;
        push(32'h0000_0055); cmp("pre_reset_r5", if32.ReadData1);
        setW(1'b0, 1'b1, 32'h0, 32'h0000_AAAA, 5'd28);
        #1;
        reset = 1'b0;
        #1;
        push(32'h0); cmp("in_reset_r5", if32.ReadData1);
        tick();
        setW(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        reset = 1'b1;
        setRd(5'd0, 5'd5);
        #1;
        push(32'h0); cmp("rst_r0", if32.ReadData1);
        push(32'h0); cmp("rst_r5", if32.ReadData2);
        setRd(5'd28, 5'd29);
        #1;
        push(32'h1000_8000); cmp("rst_r28", if32.ReadData1);
        push(32'h7FFF_EFFC); cmp("rst_r29", if32.ReadData2);
        tick();
        push(32'h0); cmp("rst_retired", if32.RetiredWrites);
        push(32'h0); cmp("rst_valid", {31'b0, if32.WB_WriteValid});

        // ALU writeback with same-cycle bypass.
        setW(1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd8);
        setRd(5'd8, 5'd0);
        #1;
        push(32'hDEAD_BEEF); cmp("alu_bypass", if32.ReadData1);
        push(32'hDEAD_BEEF); cmp("alu_wdata", if32.WB_WriteData);
        tick();
        setW(1'b0, 1'b0, 32'h0, 32'h0, 5'd8);
        #1;
        push(32'hDEAD_BEEF); cmp("alu_stored", if32.ReadData1);
        push(32'h1); cmp("alu_valid", {31'b0, if32.WB_WriteValid});
        push(32'h1); cmp("alu_retired", if32.RetiredWrites);

        // Load writeback, both ports on the write target.
        setW(1'b1, 1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 5'd9);
        setRd(5'd9, 5'd9);
        #1;
        push(32'h42); cmp("ld_wdata", if32.WB_WriteData);
        push(32'h42); cmp("ld_rd1", if32.ReadData1);
        push(32'h42); cmp("ld_rd2", if32.ReadData2);
        tick();
        setW(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        push(32'h42); cmp("ld_stored", if32.ReadData2);
        push(32'h2);  cmp("ld_retired", if32.RetiredWrites);

        // Write aimed at r0 must vanish.
        setW(1'b0, 1'b1, 32'h0, 32'h1234_5678, 5'd0);
        setRd(5'd0, 5'd0);
        #1;
        push(32'h0);          cmp("r0_same", if32.ReadData1);
        push(32'h1234_5678);  cmp("r0_wdata", if32.WB_WriteData);
        tick();
        setW(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        push(32'h0); cmp("r0_next", if32.ReadData2);
        push(32'h0); cmp("r0_valid", {31'b0, if32.WB_WriteValid});
        push(32'h2); cmp("r0_retired", if32.RetiredWrites);

        // Back-to-back writes: r10=1, r10=2, r11=3.
        setRd(5'd10, 5'd11);
        setW(1'b0, 1'b1, 32'h0, 32'h1, 5'd10);
        #1;
        push(32'h1); cmp("b2b_c0", if32.ReadData1);
        tick();
        setW(1'b0, 1'b1, 32'h0, 32'h2, 5'd10);
        #1;
        push(32'h2); cmp("b2b_c1", if32.ReadData1);
        push(32'h1); cmp("b2b_valid", {31'b0, if32.WB_WriteValid});
        tick();
        setW(1'b0, 1'b1, 32'h0, 32'h3, 5'd11);
        #1;
        push(32'h2); cmp("b2b_c2", if32.ReadData1);
        push(32'h3); cmp("b2b_r11_bypass", if32.ReadData2);
        tick();
        setW(1'b0, 1'b0, 32'h0, 32'h99, 5'd10);
        #1;
        push(32'h2); cmp("no_bypass_when_idle", if32.ReadData1);
        push(32'h3); cmp("b2b_r11_stored", if32.ReadData2);
        push(32'h5); cmp("b2b_retired", if32.RetiredWrites);
        setRd(5'd8, 5'd9);
        #1;
        push(32'hDEAD_BEEF); cmp("r8_kept", if32.ReadData1);
        push(32'h42);        cmp("r9_kept", if32.ReadData2);

        // Counter wrap on the 8-bit build: 256 effective writes.
        if8.WB_RegWrite      = 1'b1;
        if8.WB_WriteRegister = 5'd3;
        if8.WB_ALUResult     = 8'h5A;
        tick();
        for (int k = 1; k < 255; k++) begin
            if8.WB_WriteRegister = 5'd7;
            if8.WB_ALUResult     = 8'(k);
            tick();
        end
        push(32'hFF); cmp("w8_retired_255", {24'b0, if8.RetiredWrites});
        if8.WB_WriteRegister = 5'd7;
        if8.WB_ALUResult     = 8'hFF;
        tick();
        if8.WB_RegWrite   = 1'b0;
        if8.ReadRegister1 = 5'd3;
        if8.ReadRegister2 = 5'd7;
        #1;
        push(32'h0);  cmp("w8_retired_wrap", {24'b0, if8.RetiredWrites});
        push(32'h5A); cmp("w8_r3", {24'b0, if8.ReadData1});
        push(32'hFF); cmp("w8_r7", {24'b0, if8.ReadData2});
        if8.ReadRegister1 = 5'd29;
        if8.ReadRegister2 = 5'd28;
        #1;
        push(32'hFC); cmp("w8_r29", {24'b0, if8.ReadData1});
        push(32'h00); cmp("w8_r28", {24'b0, if8.ReadData2});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
